// File: rtl/dzcpu_useq_pkg.sv
// Shared constants for the dzcpu microcode sequencer: uop control codes, FSM
// state encodings, next-uPC selectors and the fixed interrupt flow index.
package dzcpu_useq_pkg;

    localparam logic [3:0] OP         = 4'd0;
    localparam logic [3:0] INC        = 4'd1;
    localparam logic [3:0] EOF        = 4'd2;
    localparam logic [3:0] INC_EOF    = 4'd3;
    localparam logic [3:0] EOF_FU     = 4'd4;
    localparam logic [3:0] INC_EOF_FU = 4'd5;
    localparam logic [3:0] UPD_FL     = 4'd6;
    localparam logic [3:0] INC_EOF_Z  = 4'd7;
    localparam logic [3:0] INC_EOF_NZ = 4'd8;
    localparam logic [3:0] JCB        = 4'd9;

    localparam logic [0:0] ST_DISPATCH = 1'b0;
    localparam logic [0:0] ST_EXEC     = 1'b1;

    localparam logic [7:0] FLOW_ID_INT = 8'd200;

    typedef enum logic [1:0] {
        NEXT_INC = 2'd0,
        NEXT_EOF = 2'd1,
        NEXT_CB  = 2'd2
    } next_sel_t;

    // Builds a uop word from a control code and payload; handy for ROM images.
    function automatic logic [12:0] make_uop(input logic [3:0] ctl, input logic [8:0] payload);
        return {ctl, payload};
    endfunction

endpackage

// File: rtl/dzcpu_useq_ctl_dec.sv
// Combinational decode of the uop control field into the next-uPC selector
// and the side-effect strobes. Codes outside the defined set act as OP.
module dzcpu_useq_ctl_dec
    import dzcpu_useq_pkg::*;
#(
    parameter int CTL_W = 4
) (
    input  logic [CTL_W-1:0] ctl,
    input  logic             flag_z,
    output next_sel_t        next_sel,
    output logic             pc_inc,
    output logic             flag_upd,
    output logic             is_eof
);

    logic [3:0] code;

    // Wider control fields with any upper bit set fall outside the code space.
    generate
        if (CTL_W > 4) begin : g_wide
            assign code = (ctl[CTL_W-1:4] == '0) ? ctl[3:0] : OP;
        end else begin : g_exact
            assign code = ctl[3:0];
        end
    endgenerate

    always_comb begin
        next_sel = NEXT_INC;
        pc_inc   = 1'b0;
        flag_upd = 1'b0;
        case (code)
            INC: begin
                pc_inc = 1'b1;
            end
            EOF: begin
                next_sel = NEXT_EOF;
            end
            INC_EOF: begin
                next_sel = NEXT_EOF;
                pc_inc   = 1'b1;
            end
            EOF_FU: begin
                next_sel = NEXT_EOF;
                flag_upd = 1'b1;
            end
            INC_EOF_FU: begin
                next_sel = NEXT_EOF;
                pc_inc   = 1'b1;
                flag_upd = 1'b1;
            end
            UPD_FL: begin
                flag_upd = 1'b1;
            end
            INC_EOF_Z: begin
                if (flag_z) begin
                    next_sel = NEXT_EOF;
                    pc_inc   = 1'b1;
                end
            end
            INC_EOF_NZ: begin
                if (!flag_z) begin
                    next_sel = NEXT_EOF;
                    pc_inc   = 1'b1;
                end
            end
            JCB: begin
                next_sel = NEXT_CB;
                pc_inc   = 1'b1;
            end
            default: begin
                next_sel = NEXT_INC;
            end
        endcase
    end

    assign is_eof = (next_sel == NEXT_EOF);

endmodule

// File: rtl/dzcpu_useq.sv
// dzcpu microcode sequencer: dispatches macro-opcodes to uop flows and steps the uPC.
// Optional interrupt dispatch is enabled by defining DZCPU_USEQ_IRQ_EN.
module dzcpu_useq
    import dzcpu_useq_pkg::*;
#(
    parameter int MOP_W = 8,
    parameter int UPC_W = 8,
    parameter int UOP_W = 13,
    parameter int CTL_W = 4
) (
    input  logic             iClock,
    input  logic             iReset_n,
    input  logic [MOP_W-1:0] iMop,
    input  logic             iMopValid,
    output logic             oMopReady,
    output logic [MOP_W-1:0] oLutMop,
    input  logic [UPC_W-1:0] iFlowIdx,
    input  logic [MOP_W-1:0] iMemData,
    input  logic [UPC_W-1:0] iCbFlowIdx,
    output logic [UPC_W-1:0] oUpc,
    input  logic [UOP_W-1:0] iUop,
    output logic [UOP_W-1:0] oUop,
    output logic             oUopValid,
    input  logic             iUopReady,
    input  logic             iFlagZ,
    output logic             oPcInc,
    output logic             oFlagUpd,
    output logic             oFault
`ifdef DZCPU_USEQ_IRQ_EN
    ,
    input  logic             iIrqReq,
    input  logic             iIme,
    output logic             oIrqAck
`endif
);

    logic [0:0]       state_reg, state_next;
    logic [UPC_W-1:0] upc_reg, upc_next;
    logic [MOP_W-1:0] mop_reg, mop_next;
    logic             pc_inc_reg, flag_upd_reg, fault_reg;
    logic             fault_set;
    logic             exec, fire, irq_take, upc_at_max;

    next_sel_t        dec_next_sel;
    logic             dec_pc_inc, dec_flag_upd, dec_is_eof;

    // The CB byte only addresses the external CB table; the sequencer consumes its result.
    logic             unused_inputs;
    assign unused_inputs = ^{iMemData, dec_is_eof};

    assign exec       = (state_reg == ST_EXEC);
    assign fire       = exec & iUopReady;
    assign upc_at_max = &upc_reg;

`ifdef DZCPU_USEQ_IRQ_EN
    logic irq_ack_reg;
    assign irq_take = ~exec & iIrqReq & iIme;
    assign oIrqAck  = irq_ack_reg;
`else
    assign irq_take = 1'b0;
`endif

    dzcpu_useq_ctl_dec #(
        .CTL_W (CTL_W)
    ) u_ctl_dec (
        .ctl      (iUop[UOP_W-1 -: CTL_W]),
        .flag_z   (iFlagZ),
        .next_sel (dec_next_sel),
        .pc_inc   (dec_pc_inc),
        .flag_upd (dec_flag_upd),
        .is_eof   (dec_is_eof)
    );

    always_comb begin
        state_next = state_reg;
        upc_next   = upc_reg;
        mop_next   = mop_reg;
        fault_set  = 1'b0;
        if (!exec) begin
            if (irq_take) begin
                upc_next   = UPC_W'(FLOW_ID_INT);
                state_next = ST_EXEC;
            end else if (iMopValid) begin
                mop_next   = iMop;
                upc_next   = iFlowIdx;
                state_next = ST_EXEC;
            end
        end else if (iUopReady) begin
            case (dec_next_sel)
                NEXT_EOF: state_next = ST_DISPATCH;
                NEXT_CB:  upc_next   = iCbFlowIdx;
                default: begin
                    // Running off the end of the ROM aborts the flow instead of wrapping.
                    if (upc_at_max) begin
                        fault_set  = 1'b1;
                        state_next = ST_DISPATCH;
                    end else begin
                        upc_next = upc_reg + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            state_reg    <= ST_DISPATCH;
            upc_reg      <= '0;
            mop_reg      <= '0;
            pc_inc_reg   <= 1'b0;
            flag_upd_reg <= 1'b0;
            fault_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            upc_reg      <= upc_next;
            mop_reg      <= mop_next;
            pc_inc_reg   <= fire & dec_pc_inc;
            flag_upd_reg <= fire & dec_flag_upd;
            fault_reg    <= fault_reg | fault_set;
        end
    end

`ifdef DZCPU_USEQ_IRQ_EN
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            irq_ack_reg <= 1'b0;
        end else begin
            irq_ack_reg <= irq_take;
        end
    end
`endif

    assign oMopReady = ~exec & ~irq_take;
    assign oLutMop   = exec ? mop_reg : iMop;
    assign oUpc      = upc_reg;
    assign oUopValid = exec;
    assign oPcInc    = pc_inc_reg;
    assign oFlagUpd  = flag_upd_reg;
    assign oFault    = fault_reg;

    // The datapath sees a zero word outside a flow so stale ROM data never leaks.
    genvar gi;
    generate
        for (gi = 0; gi < UOP_W; gi++) begin : g_uop_gate
            assign oUop[gi] = iUop[gi] & exec;
        end
    endgenerate

endmodule
